two_input_mux_32: RTL and testbench

- Parameterised 2:1 word multiplexer with a combinational output and a one-cycle registered copy.
- Also counts changes of the select input.
- Used wherever a datapath chooses between two equal-width operands (e.g. ALU operand select, writeback select).
- The combinational path is independent of clock and reset. The registered path and counter run on a single clock with asynchronous active-low reset.

---
 rtl/two_input_mux_32_pkg.sv | 16 +
 rtl/two_input_mux_32_cnt.sv | 53 +++++
 rtl/two_input_mux_32.sv | 77 +++++++
 tb/tb_two_input_mux_32.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/two_input_mux_32_pkg.sv
// -----------------------------------------------------------------------------
// two_input_mux_32_pkg
// Shared constants for the two_input_mux_32 block:
//   DEFAULT_WIDTH : default data width of a, b, out, out_q
//   DEFAULT_CNT_W : default width of the select-toggle counter
//   CNT_MAX       : saturation value of the toggle counter (2^CNT_W-1)
// -----------------------------------------------------------------------------
package two_input_mux_32_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CNT_W = 16;

  // All ones at the default counter width, i.e. 2^DEFAULT_CNT_W - 1.
  localparam logic [DEFAULT_CNT_W-1:0] CNT_MAX = '1;

endpackage : two_input_mux_32_pkg

// File: rtl/two_input_mux_32_cnt.sv
// -----------------------------------------------------------------------------
// two_input_mux_32_cnt
// Saturating counter of select-input transitions. The first sampled value of s
// after reset only seeds the history; it never counts as a toggle.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   s      in   1      select input being watched
//   cnt    out  CNT_W  number of s transitions, saturating at all ones
// -----------------------------------------------------------------------------
module two_input_mux_32_cnt
  import two_input_mux_32_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SAT_VAL = '1;

  logic s_bit;
  logic s_prev;
  logic s_prev_valid;
  logic toggle;

  // Fold X/Z onto 0 so the counter agrees with the mux, where anything that
  // is not a clean 1 selects b.
  assign s_bit  = (s === 1'b1);
  assign toggle = s_prev_valid && (s_bit != s_prev);

  // NOTE: every register is cleared in the asynchronous reset branch, so no
  // state depends on power-up values once rst_n has been asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev       <= 1'b0;
      s_prev_valid <= 1'b0;
      cnt          <= '0;
    end else begin
      // NOTE: non-blocking assignments, so toggle is evaluated against the
      // pre-edge s_prev and s_prev_valid, not the values written here.
      s_prev       <= s_bit;
      s_prev_valid <= 1'b1;
      if (toggle && (cnt != SAT_VAL)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : two_input_mux_32_cnt

// File: rtl/two_input_mux_32.sv
// -----------------------------------------------------------------------------
// two_input_mux_32
// 2:1 word multiplexer with a combinational result, a one-cycle registered
// copy and a saturating count of select transitions.
//
// Optional feature macro: TWO_INPUT_MUX_32_PARITY_EN
//   When defined, adds out_q_parity = XOR-reduction of out_q, registered
//   together with out_q.
//
// Ports:
//   clk             in   1      rising-edge clock
//   rst_n           in   1      asynchronous active-low reset
//   a               in   WIDTH  selected when s == 1
//   b               in   WIDTH  selected when s != 1 (including X/Z)
//   s               in   1      select
//   out             out  WIDTH  combinational mux result, valid during reset
//   out_q           out  WIDTH  out registered on clk
//   out_q_valid     out  1      out_q holds a sampled value since reset
//   out_q_parity    out  1      (macro only) parity of out_q
//   sel_toggle_cnt  out  CNT_W  saturating count of s transitions
// -----------------------------------------------------------------------------
module two_input_mux_32
  import two_input_mux_32_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_q_valid,
`ifdef TWO_INPUT_MUX_32_PARITY_EN
  output logic             out_q_parity,
`endif
  output logic [CNT_W-1:0] sel_toggle_cnt
);

  // Case-equality makes an unknown select fall through to b in simulation;
  // in hardware this is an ordinary 2:1 mux.
  assign out = (s === 1'b1) ? a : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_q_valid <= 1'b0;
    end else begin
      out_q       <= out;
      out_q_valid <= 1'b1;
    end
  end

`ifdef TWO_INPUT_MUX_32_PARITY_EN
  // Parity is taken from out rather than out_q so it lands on the same edge
  // as the word it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_parity <= 1'b0;
    end else begin
      out_q_parity <= ^out;
    end
  end
`endif

  two_input_mux_32_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s),
    .cnt   (sel_toggle_cnt)
  );

endmodule : two_input_mux_32

// File: tb/tb_two_input_mux_32.sv
// -----------------------------------------------------------------------------
// tb_two_input_mux_32
// Self-checking bench for two_input_mux_32. A behavioural model tracks the
// expected registered word, valid flag and toggle count from the select
// history; directed steps plus randomized operands are compared against it.
// Optional feature macro: TWO_INPUT_MUX_32_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_two_input_mux_32;
  import two_input_mux_32_pkg::*;

  localparam int unsigned W  = DEFAULT_WIDTH;
  localparam int unsigned CW = DEFAULT_CNT_W;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          s;
  logic [W-1:0]  out;
  logic [W-1:0]  out_q;
  logic          out_q_valid;
  logic [CW-1:0] sel_toggle_cnt;
`ifdef TWO_INPUT_MUX_32_PARITY_EN
  logic          out_q_parity;
`endif

  two_input_mux_32 #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a              (a),
    .b              (b),
    .s              (s),
    .out            (out),
    .out_q          (out_q),
    .out_q_valid    (out_q_valid),
`ifdef TWO_INPUT_MUX_32_PARITY_EN
    .out_q_parity   (out_q_parity),
`endif
    .sel_toggle_cnt (sel_toggle_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  logic [W-1:0] exp_q;
  bit           exp_valid;
  int           exp_cnt;
  int           last_s;   // -1 means no select sampled since reset

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_mux(input logic [W-1:0] ia,
                                             input logic [W-1:0] ib,
                                             input logic is);
    return (is === 1'b1) ? ia : ib;
  endfunction

  task automatic model_reset();
    exp_q     = '0;
    exp_valid = 0;
    exp_cnt   = 0;
    last_s    = -1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_q"}, 64'(out_q), 64'(exp_q));
    check({tag, ".valid"}, 64'(out_q_valid), 64'(exp_valid));
    check({tag, ".cnt"}, 64'(sel_toggle_cnt), 64'(exp_cnt));
`ifdef TWO_INPUT_MUX_32_PARITY_EN
    check({tag, ".parity"}, 64'(out_q_parity), 64'($countones(exp_q) % 2));
`endif
  endtask

  // One clock cycle: rising edge at +5, model update, optional check at +6,
  // falling edge at +10. Inputs are changed by the caller while clk is low.
  task automatic step(input bit do_check, input string tag);
    int cur;
    #5 clk = 1'b1;
    cur = (s === 1'b1) ? 1 : 0;
    exp_q     = model_mux(a, b, s);
    exp_valid = 1;
    if (last_s >= 0 && cur != last_s && exp_cnt < (1 << CW) - 1) exp_cnt++;
    last_s = cur;
    #1;
    if (do_check) check_regs(tag);
    #4 clk = 1'b0;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
    a     = 32'hAAAAAAAA;
    b     = 32'hCCCCCCCC;
    s     = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;

    // Combinational path with no clock running, during reset.
    #100;
    check("comb_s1", 64'(out), 64'(32'hAAAAAAAA));
    check_regs("in_reset");
    s = 1'b0;
    #1 check("comb_s0", 64'(out), 64'(32'hCCCCCCCC));
    s = 1'bx;
    #1 check("comb_sx", 64'(out), 64'(32'hCCCCCCCC));

    // Registered path: first edge loads out_q, does not count a toggle.
    s = 1'b1;
    #2 rst_n = 1'b1;
    step(1, "first_edge");
    s = 1'b0;
    #1;
    check("hold_before_edge", 64'(out_q), 64'(32'hAAAAAAAA));
    check("comb_follows", 64'(out), 64'(32'hCCCCCCCC));
    step(1, "second_edge");
    s = 1'b1; step(1, "tog2");
    s = 1'b0; step(1, "tog3");
    check("pre_reset_cnt", 64'(sel_toggle_cnt), 64'(3));

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("mid_reset");
    check("mid_reset.out", 64'(out), 64'(32'hCCCCCCCC));
    #1 rst_n = 1'b1;

    // Directed toggle sequence 1,0,1,1,0 -> 3 toggles.
    s = 1'b1; step(1, "seq0");
    s = 1'b0; step(1, "seq1");
    s = 1'b1; step(1, "seq2");
    s = 1'b1; step(1, "seq3");
    s = 1'b0; step(1, "seq4");
    check("seq_total", 64'(sel_toggle_cnt), 64'(3));

    // Randomized operands; every eighth step uses a == b.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 8 == 0) ? a : $urandom;
      s = 1'($urandom_range(0, 1));
      #1 check("rand_comb", 64'(out), 64'(model_mux(a, b, s)));
      step(1, "rand");
    end

`ifdef TWO_INPUT_MUX_32_PARITY_EN
    a = 32'h00000007; s = 1'b1; step(1, "par7");
    check("parity_odd", 64'(out_q_parity), 64'(1));
    a = 32'h00000003; step(1, "par3");
    check("parity_even", 64'(out_q_parity), 64'(0));
`endif

    // Saturation: toggle every cycle for 70000 cycles.
    #2 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      s = ~s;
      if (s === 1'bx) s = 1'b0;
      step(0, "sat");
    end
    check("sat_model", 64'(exp_cnt), 64'(CNT_MAX));
    check("sat_value", 64'(sel_toggle_cnt), 64'(CNT_MAX));
    for (int i = 0; i < 4; i++) begin
      s = ~s;
      step(1, "sat_hold");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_two_input_mux_32
